// File: rtl/shift_unit_pkg.sv
// Shared encodings for the shift/rotate engine: opcodes, operand sizes, FSM states, flag bit indices.
// Opcodes are the combinational ALU's shift codes 8-F with the top bit dropped.
package shift_unit_pkg;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_RCL = 3'd2,
    OP_RCR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_SAL = 3'd6,
    OP_SAR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SZ_8    = 2'd0,
    SZ_16   = 2'd1,
    SZ_32   = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [11:0] FLAGS_RESET = 12'h002;

  // Reserved size folds onto 32-bit; a 16-bit build folds 32-bit onto 16-bit.
  function automatic size_e eff_size(input logic [1:0] size, input int width);
    if (size == 2'd0) return SZ_8;
    if (size == 2'd1 || width < 32) return SZ_16;
    return SZ_32;
  endfunction

  function automatic logic [4:0] msb_idx(input size_e sz);
    case (sz)
      SZ_8:    return 5'd7;
      SZ_16:   return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic is_left(input op_e op);
    return (op == OP_ROL) || (op == OP_RCL) || (op == OP_SHL) || (op == OP_SAL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step on an 8/16/32-bit working value.
// Bits above the operand width are expected to be zero and are kept zero.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  size_e            size,
  input  logic [WIDTH-1:0] data,
  input  logic             cf,
  output logic [WIDTH-1:0] data_next,
  output logic             cf_next
);

  localparam int IW = $clog2(WIDTH);

  size_e            sz;
  logic [IW-1:0]    msb;
  logic [WIDTH-1:0] mask;
  logic             top;
  logic             bot;
  logic             fill;

  always_comb begin
    sz   = eff_size(size, WIDTH);
    msb  = IW'(msb_idx(sz));
    mask = '1;
    case (sz)
      SZ_8:    mask = WIDTH'(8'hFF);
      SZ_16:   mask = WIDTH'(16'hFFFF);
      default: mask = '1;
    endcase
    top       = data[msb];
    bot       = data[0];
    fill      = 1'b0;
    data_next = '0;
    cf_next   = cf;
    if (is_left(op)) begin
      case (op)
        OP_ROL:  fill = top;
        OP_RCL:  fill = cf;
        default: fill = 1'b0;
      endcase
      data_next = ((data << 1) & mask) | WIDTH'(fill);
      cf_next   = top;
    end else begin
      case (op)
        OP_ROR:  fill = bot;
        OP_RCR:  fill = cf;
        OP_SAR:  fill = top;
        default: fill = 1'b0;
      endcase
      data_next = (data >> 1) | (WIDTH'(fill) << msb);
      cf_next   = bot;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle x86 shift/rotate engine, one bit position per clock; valid pulses N+1 cycles after start.
// start is taken only while ready=1 (never queued); flush aborts with no valid and held outputs.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] op1,
  input  logic [7:0]       count,
  input  logic [11:0]      flags,
  input  logic             flush,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [11:0]      flags_out
);

  localparam int IW = $clog2(WIDTH);

  state_e                state_q, state_d;
  op_e                   op_q;
  size_e                 sz_q;
  logic [WIDTH-1:0]      data_q;
  logic                  cf_q;
  logic [11:0]           flags_q;
  logic                  orig_msb_q;
  logic                  zero_cnt_q;
  logic [CNT_BITS-1:0]   rem_q;
  logic                  valid_q;
  logic [WIDTH-1:0]      result_q;
  logic [11:0]           flags_out_q;

  logic                  accept;
  logic [CNT_BITS-1:0]   n_eff;
  size_e                 in_sz;
  logic [IW-1:0]         in_msb;
  logic [WIDTH-1:0]      in_mask;
  logic [IW-1:0]         cur_msb;
  logic                  res_msb;
  logic                  res_msb1;
  logic [11:0]           flags_calc;
  logic [WIDTH-1:0]      step_data;
  logic                  step_cf;
  logic                  unused_count_hi;

  assign unused_count_hi = ^count[7:CNT_BITS];

  assign n_eff  = count[CNT_BITS-1:0];
  assign accept = (state_q == ST_IDLE) && start && !flush;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .size      (sz_q),
    .data      (data_q),
    .cf        (cf_q),
    .data_next (step_data),
    .cf_next   (step_cf)
  );

  always_comb begin
    in_sz   = eff_size(size, WIDTH);
    in_msb  = IW'(msb_idx(in_sz));
    in_mask = '1;
    case (in_sz)
      SZ_8:    in_mask = WIDTH'(8'hFF);
      SZ_16:   in_mask = WIDTH'(16'hFFFF);
      default: in_mask = '1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (n_eff == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: begin
        if (flush)                          state_d = ST_IDLE;
        else if (rem_q == CNT_BITS'(1))     state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flags are evaluated on the final working state while sitting in DONE.
  always_comb begin
    cur_msb    = IW'(msb_idx(sz_q));
    res_msb    = data_q[cur_msb];
    res_msb1   = data_q[cur_msb - IW'(1)];
    flags_calc = flags_q;
    if (!zero_cnt_q) begin
      flags_calc[1]       = 1'b1;
      flags_calc[3]       = 1'b0;
      flags_calc[5]       = 1'b0;
      flags_calc[FLAG_CF] = cf_q;
      if (op_q[2]) begin
        flags_calc[FLAG_SF] = res_msb;
        flags_calc[FLAG_ZF] = (data_q == '0);
        flags_calc[FLAG_PF] = ~^data_q[7:0];
        flags_calc[FLAG_AF] = 1'b0;
      end
      case (op_q)
        OP_ROL, OP_RCL, OP_SHL, OP_SAL: flags_calc[FLAG_OF] = res_msb ^ cf_q;
        OP_ROR, OP_RCR:                 flags_calc[FLAG_OF] = res_msb ^ res_msb1;
        OP_SHR:                         flags_calc[FLAG_OF] = orig_msb_q;
        default:                        flags_calc[FLAG_OF] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= OP_ROL;
      sz_q        <= SZ_8;
      data_q      <= '0;
      cf_q        <= 1'b0;
      flags_q     <= FLAGS_RESET;
      orig_msb_q  <= 1'b0;
      zero_cnt_q  <= 1'b1;
      rem_q       <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      flags_out_q <= FLAGS_RESET;
    end else begin
      if (accept) begin
        op_q       <= op_e'(op);
        sz_q       <= in_sz;
        data_q     <= op1 & in_mask;
        cf_q       <= flags[FLAG_CF];
        flags_q    <= flags;
        orig_msb_q <= op1[in_msb];
        zero_cnt_q <= (n_eff == '0);
        rem_q      <= n_eff;
      end else if (state_q == ST_SHIFT) begin
        data_q <= step_data;
        cf_q   <= step_cf;
        rem_q  <= rem_q - CNT_BITS'(1);
      end
      valid_q <= (state_q == ST_DONE) && !flush;
      if ((state_q == ST_DONE) && !flush) begin
        result_q    <= data_q;
        flags_out_q <= flags_calc;
      end
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign valid     = valid_q;
  assign result    = result_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit: latency, result and flag word per operation plus flush/reset/start-ignore cases.
module tb_shift_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  size;
  logic [31:0] op1;
  logic [7:0]  count;
  logic [11:0] flags;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [31:0] result;
  logic [11:0] flags_out;

  int err_cnt = 0;
  int chk_cnt = 0;

  shift_unit #(.WIDTH(32), .CNT_BITS(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .size      (size),
    .op1       (op1),
    .count     (count),
    .flags     (flags),
    .flush     (flush),
    .ready     (ready),
    .valid     (valid),
    .result    (result),
    .flags_out (flags_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [2:0] o, input logic [1:0] s, input logic [31:0] a,
                        input logic [7:0] c, input logic [11:0] f);
    op = o; size = s; op1 = a; count = c; flags = f; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from the start edge until valid; pokes a stray start during SHIFT when asked.
  task automatic wait_valid(input bit poke, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 2) begin
        op = 3'd4; op1 = 32'hFF; count = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat = i;
      if (valid) break;
      if (i == 40) lat = 41;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s,
                        input logic [31:0] a, input logic [7:0] c, input logic [11:0] f,
                        input int exp_lat, input logic [31:0] exp_res, input logic [11:0] exp_flags);
    int lat;
    launch(o, s, a, c, f);
    wait_valid(1'b0, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flg"}, 32'(flags_out), 32'(exp_flags));
  endtask

  initial begin
    int lat;
    int vcount;
    reset_n = 1'b0; start = 1'b0; op = '0; size = '0; op1 = '0;
    count = '0; flags = '0; flush = 1'b0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", 32'(flags_out), 32'h002);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    run_op("shl8",   3'd4, 2'd0, 32'h81,       8'd1,  12'h000, 2,  32'h02,       12'h803);
    run_op("rol8",   3'd0, 2'd0, 32'h80,       8'd1,  12'h0C4, 2,  32'h01,       12'h8C7);
    run_op("rcr16",  3'd3, 2'd1, 32'h0001,     8'd17, 12'h000, 18, 32'h0001,     12'h002);
    run_op("sar32",  3'd7, 2'd2, 32'h80000000, 8'd31, 12'h000, 32, 32'hFFFFFFFF, 12'h086);
    run_op("cnt0",   3'd4, 2'd2, 32'hDEADBEEF, 8'h20, 12'h8D5, 1,  32'hDEADBEEF, 12'h8D5);
    run_op("ror32",  3'd1, 2'd2, 32'h00000001, 8'd1,  12'h000, 2,  32'h80000000, 12'h803);
    run_op("rcl8",   3'd2, 2'd0, 32'h80,       8'd9,  12'h001, 10, 32'h80,       12'h003);
    run_op("sal16",  3'd6, 2'd1, 32'h4000,     8'd1,  12'h000, 2,  32'h8000,     12'h886);
    run_op("mask8",  3'd5, 2'd0, 32'hFFFF_FF10, 8'd0, 12'h000, 1,  32'h10,       12'h000);

    // Stray start during SHIFT must not alter the running op nor queue another.
    launch(3'd5, 2'd0, 32'h80, 8'd4, 12'h000);
    wait_valid(1'b1, lat);
    check("poke_lat", 32'(lat), 32'd5);
    check("poke_res", result, 32'h08);
    check("poke_flg", 32'(flags_out), 32'h802);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) vcount++;
    end
    check("poke_novalid", 32'(vcount), 32'd0);

    // Flush mid-SHIFT: back to idle, outputs hold, no valid afterwards.
    launch(3'd4, 2'd0, 32'h01, 8'd10, 12'h000);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_res", result, 32'h08);
    check("flush_flg", 32'(flags_out), 32'h802);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid) vcount++;
    end
    check("flush_novalid", 32'(vcount), 32'd0);
    run_op("shr16", 3'd5, 2'd1, 32'h8001, 8'd1, 12'h000, 2, 32'h4000, 12'h807);

    // Asynchronous reset mid-SHIFT.
    launch(3'd7, 2'd2, 32'h12345678, 8'd20, 12'h000);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_result", result, 32'h0);
    check("arst_flags", 32'(flags_out), 32'h002);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    run_op("post_rst", 3'd4, 2'd0, 32'h81, 8'd1, 12'h000, 2, 32'h02, 12'h803);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
